// File: rtl/hhmm_level_n_if.sv
// Bitstream and status bundle between one HHMM level and its parent/sub-level controller.
// The level itself connects through the slave modport.
interface hhmm_level_n_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 16
);
  logic [1:0]     MODE;
  logic [N-1:0]   PI_RAW;
  logic [N*N-1:0] P_RAW;
  logic [N-1:0]   PE_RAW;
  logic [N-1:0]   S;
  logic           T;
  logic           DEC;
  logic           STALL;
  logic [CW-1:0]  DEC_CNT;

  modport master (
    output MODE, PI_RAW, P_RAW, PE_RAW,
    input  S, T, DEC, STALL, DEC_CNT
  );

  modport slave (
    input  MODE, PI_RAW, P_RAW, PE_RAW,
    output S, T, DEC, STALL, DEC_CNT
  );
endinterface

// File: rtl/hhmm_level_n.sv
// One N-state level of the stochastic hierarchical HMM: one-hot state advanced by sampled
// bitstreams, with stochastic entry/exit, sub-level retention, stall watchdog and decision count.
module hhmm_level_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CW       = 16
) (
  input logic          CLK,
  input logic          INIT_N,
  hhmm_level_n_if.slave bus
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WaitLast = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StEnter, StRun, StSub, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mem_q, mem_d;
  logic [N-1:0]   s_q, s_d;
  logic           t_q, t_d;
  logic           dec_q, dec_d;
  logic           stall_q, stall_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   row;
  logic           pe_k;
  logic           pi_hit, run_hit, exit_hit;
  logic [WW-1:0]  wait_tick;
  logic           stall_tick;

  // Row and exit bit of the currently held state; MEM is one-hot so at most one i matches.
  always_comb begin
    row  = '0;
    pe_k = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (mem_q[i]) begin
        row  = bus.P_RAW[i*N +: N];
        pe_k = bus.PE_RAW[i];
      end
    end
  end

  assign pi_hit   = $onehot(bus.PI_RAW);
  assign run_hit  = $onehot({pe_k, row});
  assign exit_hit = run_hit && pe_k;

  // Watchdog step for a search cycle that produced no decision.
  assign stall_tick = (wait_q == WaitLast);
  assign wait_tick  = stall_tick ? '0 : wait_q + WW'(1);

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (bus.MODE)
      2'd0: state_d = StIdle;
      2'd3: state_d = StEnter;
      2'd2: if (state_q == StRun) state_d = StSub;
      2'd1: begin
        case (state_q)
          StEnter: if (pi_hit) state_d = StRun;
          StRun:   if (exit_hit) state_d = StDone;
          StSub:   state_d = StRun;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    s_d     = s_q;
    t_d     = t_q;
    dec_d   = 1'b0;
    stall_d = 1'b0;
    wait_d  = wait_q;
    unique case (bus.MODE)
      2'd0, 2'd3: begin
        mem_d  = '0;
        s_d    = '0;
        t_d    = 1'b0;
        wait_d = '0;
      end
      2'd2: begin
        // Sub-level owns the hierarchy: hide S, keep MEM and the watchdog frozen.
        if (state_q == StRun || state_q == StEnter) s_d = '0;
      end
      2'd1: begin
        case (state_q)
          StEnter: begin
            if (pi_hit) begin
              mem_d  = bus.PI_RAW;
              s_d    = bus.PI_RAW;
              dec_d  = 1'b1;
              wait_d = '0;
            end else begin
              wait_d  = wait_tick;
              stall_d = stall_tick;
            end
          end
          StRun: begin
            if (exit_hit) begin
              mem_d  = '0;
              s_d    = '0;
              t_d    = 1'b1;
              dec_d  = 1'b1;
              wait_d = '0;
            end else if (run_hit) begin
              mem_d  = row;
              s_d    = row;
              dec_d  = 1'b1;
              wait_d = '0;
            end else begin
              wait_d  = wait_tick;
              stall_d = stall_tick;
            end
          end
          StSub: s_d = mem_q;
          StDone: begin
            s_d = '0;
            t_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    cnt_d = (dec_d && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      mem_q   <= '0;
      s_q     <= '0;
      t_q     <= 1'b0;
      dec_q   <= 1'b0;
      stall_q <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      s_q     <= s_d;
      t_q     <= t_d;
      dec_q   <= dec_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.T       = t_q;
  assign bus.DEC     = dec_q;
  assign bus.STALL   = stall_q;
  assign bus.DEC_CNT = cnt_q;

endmodule

// File: tb/tb_hhmm_level_n.sv
// Directed bench for hhmm_level_n (N=4, MAX_WAIT=8); a CW=2 twin on the same inputs
// exercises DEC_CNT saturation.
module tb_hhmm_level_n;

  logic clk;
  logic init_n;
  int   passed;
  int   total;
  logic [22:0] obs;
  logic [22:0] exp;

  hhmm_level_n_if #(.N(4), .CW(16)) bus ();
  hhmm_level_n_if #(.N(4), .CW(2))  bus2 ();

  assign bus2.MODE   = bus.MODE;
  assign bus2.PI_RAW = bus.PI_RAW;
  assign bus2.P_RAW  = bus.P_RAW;
  assign bus2.PE_RAW = bus.PE_RAW;

  hhmm_level_n #(.N(4), .MAX_WAIT(8), .CW(16)) dut (
    .CLK    (clk),
    .INIT_N (init_n),
    .bus    (bus)
  );

  hhmm_level_n #(.N(4), .MAX_WAIT(8), .CW(2)) dut_sat (
    .CLK    (clk),
    .INIT_N (init_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    init_n      = 1'b0;
    bus.MODE    = 2'd0;
    bus.PI_RAW  = '0;
    bus.P_RAW   = '0;
    bus.PE_RAW  = '0;
    #12;
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    total++;
    if (obs !== exp) $display("FAIL reset obs=%h exp=%h", obs, exp); else passed++;
    @(negedge clk);
    init_n = 1'b1;
    step();
  endtask

  task automatic test_entry();
    bus.MODE = 2'd3;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    total++;
    if (obs !== exp) $display("FAIL arm obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE   = 2'd1;
    bus.PI_RAW = 4'b0110;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    total++;
    if (obs !== exp) $display("FAIL entry_multi obs=%h exp=%h", obs, exp); else passed++;
    bus.PI_RAW = 4'b0100;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0100, 1'b0, 1'b1, 1'b0, 16'd1};
    total++;
    if (obs !== exp) $display("FAIL entry_onehot obs=%h exp=%h", obs, exp); else passed++;
  endtask

  task automatic test_transition();
    bus.P_RAW        = '0;
    bus.P_RAW[11:8]  = 4'b0011;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0100, 1'b0, 1'b0, 1'b0, 16'd1};
    total++;
    if (obs !== exp) $display("FAIL trans_multi obs=%h exp=%h", obs, exp); else passed++;
    bus.P_RAW[11:8] = 4'b0001;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0001, 1'b0, 1'b1, 1'b0, 16'd2};
    total++;
    if (obs !== exp) $display("FAIL trans_2to0 obs=%h exp=%h", obs, exp); else passed++;
    bus.P_RAW       = '0;
    bus.P_RAW[3:0]  = 4'b0001;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0001, 1'b0, 1'b1, 1'b0, 16'd3};
    total++;
    if (obs !== exp) $display("FAIL trans_self obs=%h exp=%h", obs, exp); else passed++;
    bus.PE_RAW = 4'b0001;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0001, 1'b0, 1'b0, 1'b0, 16'd3};
    total++;
    if (obs !== exp) $display("FAIL trans_exit_clash obs=%h exp=%h", obs, exp); else passed++;
    bus.PE_RAW     = '0;
    bus.P_RAW      = '0;
    bus.P_RAW[7:4] = 4'b0010;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0001, 1'b0, 1'b0, 1'b0, 16'd3};
    total++;
    if (obs !== exp) $display("FAIL trans_other_row obs=%h exp=%h", obs, exp); else passed++;
  endtask

  task automatic test_exit();
    logic [15:0] pats [4];
    pats[0] = 16'hFFFF;
    pats[1] = 16'h1248;
    pats[2] = 16'h0001;
    pats[3] = 16'h8421;
    bus.P_RAW  = '0;
    bus.PE_RAW = 4'b0001;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b1, 1'b1, 1'b0, 16'd4};
    total++;
    if (obs !== exp) $display("FAIL exit obs=%h exp=%h", obs, exp); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus.P_RAW  = pats[i];
      bus.PE_RAW = pats[i][3:0];
      bus.PI_RAW = pats[i][7:4];
      step();
      obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
      exp = {4'b0000, 1'b1, 1'b0, 1'b0, 16'd4};
      total++;
      if (obs !== exp) $display("FAIL done_hold[%0d] obs=%h exp=%h", i, obs, exp); else passed++;
    end
    bus.MODE = 2'd2;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b1, 1'b0, 1'b0, 16'd4};
    total++;
    if (obs !== exp) $display("FAIL done_mode2 obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE = 2'd3;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd4};
    total++;
    if (obs !== exp) $display("FAIL done_rearm obs=%h exp=%h", obs, exp); else passed++;
  endtask

  task automatic test_sub();
    bus.MODE   = 2'd1;
    bus.PI_RAW = 4'b1000;
    bus.P_RAW  = '0;
    bus.PE_RAW = '0;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b1000, 1'b0, 1'b1, 1'b0, 16'd5};
    total++;
    if (obs !== exp) $display("FAIL sub_enter3 obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE         = 2'd2;
    bus.P_RAW[15:12] = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd5};
      total++;
      if (obs !== exp) $display("FAIL sub_hidden[%0d] obs=%h exp=%h", i, obs, exp); else passed++;
    end
    bus.MODE  = 2'd1;
    bus.P_RAW = '0;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b1000, 1'b0, 1'b0, 1'b0, 16'd5};
    total++;
    if (obs !== exp) $display("FAIL sub_resume obs=%h exp=%h", obs, exp); else passed++;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b1000, 1'b0, 1'b0, 1'b0, 16'd5};
    total++;
    if (obs !== exp) $display("FAIL sub_run obs=%h exp=%h", obs, exp); else passed++;
  endtask

  task automatic test_stall();
    bus.MODE = 2'd3;
    step();
    bus.MODE   = 2'd1;
    bus.PI_RAW = 4'b1000;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b1000, 1'b0, 1'b1, 1'b0, 16'd6};
    total++;
    if (obs !== exp) $display("FAIL stall_entry obs=%h exp=%h", obs, exp); else passed++;
    bus.PI_RAW = '0;
    bus.P_RAW  = '0;
    bus.PE_RAW = '0;
    for (int i = 0; i < 24; i++) begin
      step();
      obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
      exp = {4'b1000, 1'b0, 1'b0, ((i % 8) == 7), 16'd6};
      total++;
      if (obs !== exp) $display("FAIL stall[%0d] obs=%h exp=%h", i, obs, exp); else passed++;
    end
  endtask

  task automatic test_mode_priority();
    bus.P_RAW[15:12] = 4'b0010;
    bus.MODE         = 2'd0;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd6};
    total++;
    if (obs !== exp) $display("FAIL sleep_wins obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE   = 2'd1;
    bus.PI_RAW = 4'b0010;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd6};
    total++;
    if (obs !== exp) $display("FAIL idle_search obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE = 2'd3;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd6};
    total++;
    if (obs !== exp) $display("FAIL init_wins obs=%h exp=%h", obs, exp); else passed++;
    bus.MODE = 2'd1;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0010, 1'b0, 1'b1, 1'b0, 16'd7};
    total++;
    if (obs !== exp) $display("FAIL reentry obs=%h exp=%h", obs, exp); else passed++;
  endtask

  task automatic test_saturation();
    total++;
    if (bus2.DEC_CNT !== 2'd3) $display("FAIL dec_cnt_sat got=%0d want=3", bus2.DEC_CNT);
    else passed++;
  endtask

  task automatic test_async_reset();
    bus.PI_RAW = '0;
    bus.P_RAW  = '0;
    #3;
    init_n = 1'b0;
    #1;
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    total++;
    if (obs !== exp) $display("FAIL async_reset obs=%h exp=%h", obs, exp); else passed++;
    total++;
    if (bus2.DEC_CNT !== 2'd0) $display("FAIL async_reset_sat got=%0d want=0", bus2.DEC_CNT);
    else passed++;
    #1;
    init_n     = 1'b1;
    bus.MODE   = 2'd1;
    bus.PI_RAW = 4'b0001;
    step();
    obs = {bus.S, bus.T, bus.DEC, bus.STALL, bus.DEC_CNT};
    exp = {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    total++;
    if (obs !== exp) $display("FAIL post_reset_idle obs=%h exp=%h", obs, exp); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_entry();
    test_transition();
    test_exit();
    test_sub();
    test_stall();
    test_mode_priority();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
